// File: rtl/serial_line_rx_if.sv
// Serial receive bundle: line input plus framed-word results.
// master drives the line; slave is the receiver.
interface serial_line_rx_if #(
    parameter int DATA_BITS = 8
);
    logic                 rx;
    logic [DATA_BITS-1:0] data_out;
    logic                 valid;
    logic                 frame_err;
    logic                 busy;

    modport master (
        output rx,
        input  data_out,
        input  valid,
        input  frame_err,
        input  busy
    );

    modport slave (
        input  rx,
        output data_out,
        output valid,
        output frame_err,
        output busy
    );
endinterface

// File: rtl/serial_line_rx.sv
// Serial line receiver: 2-flop synchronizer, start/data/stop framing,
// one-cycle valid / frame_err strobes, break hold-off after a bad stop bit.
module serial_line_rx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8
) (
    input logic             clk,
    input logic             rst,
    serial_line_rx_if.slave bus
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_BITS);

    // The IDLE detection cycle is the first clock of the half bit.
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 2);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] IDX_LAST  = BW'(DATA_BITS - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [BW-1:0] IDX_ONE   = BW'(1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } state_t;

    state_t               state;
    logic [1:0]           sync;
    logic                 rxs;
    logic [CW-1:0]        cnt;
    logic [BW-1:0]        idx;
    logic [DATA_BITS-1:0] shreg;
    logic [DATA_BITS-1:0] data_q;
    logic                 valid_q;
    logic                 ferr_q;
    logic                 busy_q;

    assign rxs = sync[1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync <= 2'b11;
        end else begin
            sync <= {sync[0], bus.rx};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            idx     <= '0;
            shreg   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            unique case (state)
                IDLE: begin
                    cnt <= '0;
                    if (!rxs) begin
                        state  <= START;
                        busy_q <= 1'b1;
                    end
                end
                START: begin
                    if (cnt == HALF_LAST) begin
                        cnt <= '0;
                        idx <= '0;
                        if (rxs) begin
                            state  <= IDLE;
                            busy_q <= 1'b0;
                        end else begin
                            state <= DATA;
                        end
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                DATA: begin
                    if (cnt == BIT_LAST) begin
                        cnt   <= '0;
                        shreg <= {rxs, shreg[DATA_BITS-1:1]};
                        idx   <= idx + IDX_ONE;
                        if (idx == IDX_LAST) begin
                            state <= STOP;
                        end
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                STOP: begin
                    if (cnt == BIT_LAST) begin
                        cnt <= '0;
                        if (rxs) begin
                            data_q  <= shreg;
                            valid_q <= 1'b1;
                            state   <= IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            ferr_q <= 1'b1;
                            state  <= BREAK;
                        end
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                BREAK: begin
                    cnt <= '0;
                    if (rxs) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    cnt    <= '0;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.data_out  = data_q;
    assign bus.valid     = valid_q;
    assign bus.frame_err = ferr_q;
    assign bus.busy      = busy_q;
endmodule

// File: tb/tb_serial_line_rx.sv
// Bench for serial_line_rx: vector table, corner sequences, random frames
// against a frame-level model, and a small-parameter variant.
module tb_serial_line_rx;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    serial_line_rx_if #(.DATA_BITS(8)) ifa ();
    serial_line_rx_if #(.DATA_BITS(7)) ifb ();

    serial_line_rx #(.CLKS_PER_BIT(16), .DATA_BITS(8)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (ifa)
    );

    serial_line_rx #(.CLKS_PER_BIT(4), .DATA_BITS(7)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (ifb)
    );

    typedef struct {
        int         cyc;
        bit         err;
        logic [7:0] data;
    } exp_t;

    typedef struct {
        logic [7:0] data;
        int         stop_low;
        int         gap;
        bit         exp_err;
        logic [7:0] exp_data;
    } vec_t;

    exp_t exp_q[$];
    vec_t vecs[5];

    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at cycle %0d",
                     name, act, req, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_rx(input bit sel, input logic v);
        if (sel) ifb.rx = v;
        else ifa.rx = v;
    endtask

    task automatic drive_frame(input bit sel, input int cpb, input int nb,
                               input logic [8:0] d, input int stop_low);
        set_rx(sel, 1'b0);
        tick(cpb);
        for (int i = 0; i < nb; i++) begin
            set_rx(sel, d[i]);
            tick(cpb);
        end
        if (stop_low == 0) begin
            set_rx(sel, 1'b1);
            tick(cpb);
        end else begin
            set_rx(sel, 1'b0);
            tick(stop_low * cpb);
            set_rx(sel, 1'b1);
        end
    endtask

    // Pulse lands 2 sync clocks + half bit + (8+1) bits after rx falls.
    task automatic send_a(input logic [7:0] d, input int stop_low,
                          input bit exp_err, input logic [7:0] exp_d);
        exp_t e;
        e.cyc  = cyc + 154;
        e.err  = exp_err;
        e.data = exp_d;
        exp_q.push_back(e);
        drive_frame(1'b0, 16, 8, {1'b0, d}, stop_low);
        if (stop_low > 0) begin
            chk("busy_in_break", ifa.busy, 1);
            tick(3);
            chk("busy_after_break", ifa.busy, 0);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (ifa.valid && ifa.frame_err) begin
                checks++;
                failures++;
                $display("FAIL valid_and_err both high at cycle %0d", cyc);
            end
            if (ifa.valid || ifa.frame_err) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_pulse valid=%0b err=%0b required none at cycle %0d",
                             ifa.valid, ifa.frame_err, cyc);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("pulse_cycle", cyc, e.cyc);
                    chk("pulse_is_err", ifa.frame_err, e.err);
                    chk("data_out", ifa.data_out, e.data);
                    chk("busy_at_pulse", ifa.busy, e.err ? 1 : 0);
                end
            end
        end
    end

    initial begin
        logic [7:0] last_good;
        logic [7:0] d;
        int         r;
        int         got;

        vecs[0] = '{8'hA5, 0, 2, 1'b0, 8'hA5};
        vecs[1] = '{8'h00, 0, 0, 1'b0, 8'h00};
        vecs[2] = '{8'hFF, 0, 3, 1'b0, 8'hFF};
        vecs[3] = '{8'h3C, 3, 2, 1'b1, 8'hFF};
        vecs[4] = '{8'h81, 0, 2, 1'b0, 8'h81};

        ifa.rx = 1'b1;
        ifb.rx = 1'b1;
        tick(3);
        chk("rst_data_out", ifa.data_out, 0);
        chk("rst_valid", ifa.valid, 0);
        chk("rst_frame_err", ifa.frame_err, 0);
        chk("rst_busy", ifa.busy, 0);
        chk("rst_b_data_out", ifb.data_out, 0);
        chk("rst_b_busy", ifb.busy, 0);
        rst = 1'b0;
        tick(5);

        foreach (vecs[i]) begin
            send_a(vecs[i].data, vecs[i].stop_low,
                   vecs[i].exp_err, vecs[i].exp_data);
            tick(vecs[i].gap * 16);
        end

        // Short low glitch must abort in START.
        ifa.rx = 1'b0;
        tick(4);
        ifa.rx = 1'b1;
        tick(2);
        chk("glitch_busy_high", ifa.busy, 1);
        tick(20);
        chk("glitch_busy_low", ifa.busy, 0);
        chk("glitch_data_kept", ifa.data_out, 8'h81);

        // Reset pulse in the middle of data bit 4.
        d = 8'hC3;
        ifa.rx = 1'b0;
        tick(16);
        for (int i = 0; i < 4; i++) begin
            ifa.rx = d[i];
            tick(16);
        end
        ifa.rx = d[4];
        tick(8);
        chk("pre_rst_busy", ifa.busy, 1);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_data_out", ifa.data_out, 0);
        chk("async_rst_busy", ifa.busy, 0);
        chk("async_rst_valid", ifa.valid, 0);
        chk("async_rst_err", ifa.frame_err, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        ifa.rx = 1'b1;
        tick(60);
        chk("post_rst_busy", ifa.busy, 0);
        send_a(8'h5A, 0, 1'b0, 8'h5A);
        tick(32);

        last_good = 8'h5A;
        for (int n = 0; n < 20; n++) begin
            int  stop_low;
            int  gap;
            bit  err;
            d        = 8'($urandom);
            err      = ($urandom_range(0, 4) == 0);
            stop_low = err ? $urandom_range(1, 3) : 0;
            gap      = err ? $urandom_range(1, 3) : $urandom_range(0, 3);
            if (!err) last_good = d;
            send_a(d, stop_low, err, last_good);
            tick(gap * 16);
        end

        r   = cyc;
        got = -1;
        fork
            drive_frame(1'b1, 4, 7, 9'h055, 0);
            begin
                for (int i = 0; i < 80; i++) begin
                    @(posedge clk);
                    #1;
                    if (ifb.valid && got < 0) got = cyc;
                    if (ifb.frame_err) chk("b_frame_err", ifb.frame_err, 0);
                end
            end
        join
        chk("b_latency", got, r + 36);
        chk("b_data_out", ifb.data_out, 7'h55);
        chk("b_busy_idle", ifb.busy, 0);

        tick(200);
        chk("missing_pulses", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
